// File: rtl/rv_in_port_fifo.sv
// Ready/valid input buffer: first-word fall-through FIFO with registered rdy/ivld,
// or a purely combinational pass-through when depth is 0.
module rv_in_port_fifo #(
    parameter int rscid = 1,
    parameter int width = 8,
    parameter int depth = 2,
    localparam int CW = (depth < 1) ? 1 : $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [width-1:0] dat,
    input  logic             vld,
    output logic             rdy,
    output logic [width-1:0] idat,
    output logic             ivld,
    input  logic             irdy,
    output logic [CW-1:0]    count
);

    // rscid only labels the instance for tool binding
    localparam int unused_rscid = rscid;

    if (depth == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ arst_n;

        assign idat  = dat;
        assign rdy   = irdy;
        assign ivld  = vld;
        assign count = '0;
    end else begin : g_fifo
        localparam int PW = (depth < 2) ? 1 : $clog2(depth);
        localparam logic [PW-1:0] LAST = PW'(depth - 1);
        localparam logic [CW-1:0] FULL = CW'(depth);

        logic [width-1:0] mem_q [depth];
        logic [width-1:0] mem_d [depth];
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    count_q, count_d;
        logic             push, pop;

        always_comb begin
            push     = vld && (count_q != FULL);
            pop      = irdy && (count_q != '0);
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push) begin
                mem_d[wr_ptr_q] = dat;
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage is never reset; the empty mask on idat hides stale contents.
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end

        assign rdy   = (count_q != FULL);
        assign ivld  = (count_q != '0);
        assign idat  = ivld ? mem_q[rd_ptr_q] : '0;
        assign count = count_q;
    end

endmodule

// File: doc/rv_in_port_fifo.md
RV_IN_PORT_FIFO -- requirements
Module: rv_in_port_fifo

Interface
REQ-001 The block SHALL have parameter rscid, default 1, resource identifier carried for tool binding only, with no functional effect.
REQ-002 The block SHALL have parameter width, default 8, data width in bits, legal range 1..1024.
REQ-003 The block SHALL have parameter depth, default 2, buffer entries; 0 selects pass-through mode, legal range 0..64.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port arst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port dat, input, width bits, producer data.
REQ-007 The block SHALL have port vld, input, 1 bit, producer valid.
REQ-008 The block SHALL have port rdy, output, 1 bit, ready to producer.
REQ-009 The block SHALL have port idat, output, width bits, data to the design.
REQ-010 The block SHALL have port ivld, output, 1 bit, valid to the design.
REQ-011 The block SHALL have port irdy, input, 1 bit, ready from the design.
REQ-012 The block SHALL have port count, output, CW bits, current occupancy, where CW = max(1, ceil(log2(depth+1))).

Function
REQ-013 In depth=0 mode the block SHALL be purely combinational: idat=dat, rdy=irdy, ivld=vld, count=0, with no registers.
REQ-014 In depth>=1 mode a push SHALL occur on a clock edge when vld=1 and rdy=1.
REQ-015 In depth>=1 mode a pop SHALL occur on a clock edge when ivld=1 and irdy=1.
REQ-016 rdy SHALL equal (count != depth) and SHALL be derived from registered state only, with no combinational path from irdy or vld.
REQ-017 ivld SHALL equal (count != 0) and SHALL be derived from registered state only, with no combinational path from vld or irdy.
REQ-018 idat SHALL present the oldest stored entry (first-word fall-through) when ivld=1, and SHALL be all-zeros when ivld=0.
REQ-019 Latency from push to ivld=1 SHALL be exactly 1 cycle when the buffer was empty; an empty buffer SHALL NOT forward dat combinationally.
REQ-020 A push with no pop SHALL increment count by 1.
REQ-021 A pop with no push SHALL decrement count by 1.
REQ-022 A simultaneous push and pop SHALL leave count unchanged, store the new entry, and advance the head.
REQ-023 When full (count=depth), rdy=0 SHALL block the push even if irdy=1 in the same cycle; a freed slot SHALL become visible on rdy one cycle later.
REQ-024 Write and read pointers SHALL range 0..depth-1 and wrap from depth-1 to 0, including for depth values that are not a power of 2.
REQ-025 Data order SHALL be strictly FIFO, with no loss or duplication under any vld/irdy pattern.
REQ-026 A vld=1 while rdy=0 SHALL be ignored, with no state change.
REQ-027 An irdy=1 while ivld=0 SHALL be ignored, with no state change.
REQ-028 For depth=1 the block SHALL behave as a single-entry register: alternating full/empty, maximum throughput of one transfer every 2 cycles.
REQ-029 For depth>=2 sustained vld=1, irdy=1 SHALL achieve one transfer per cycle after the first fill cycle.

Reset
REQ-030 While arst_n=0, count SHALL be 0, both pointers 0, ivld=0, rdy=1 (depth>=1), and idat all-zeros, independent of clk.
REQ-031 Storage contents SHALL NOT require reset; idat SHALL be masked to zero while empty.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries immediately; the first clock edge after arst_n deasserts SHALL accept a push if vld=1.
REQ-033 In depth=0 mode reset SHALL have no effect on outputs.

Verification
REQ-034 width=8, depth=4: push 0x11,0x22,0x33,0x44 with irdy=0 -> count=4, rdy=0; then irdy=1 for 4 cycles -> idat 0x11,0x22,0x33,0x44 in order, count returns to 0, ivld=0, idat=0x00.
REQ-035 width=8, depth=4, full; in one cycle assert vld=1 dat=0x55 with irdy=1 -> 0x11 popped, 0x55 not accepted, count=3; next cycle rdy=1 and 0x55 accepted.
REQ-036 width=8, depth=3: push and pop continuously for 10 items 0x01..0x0A -> exact order out, pointers wrap 2->0, count never exceeds 3.
REQ-037 width=8, depth=1: vld=1 and irdy=1 held with dat incrementing from 0x00 -> accepted values 0x00,0x01,... one per 2 cycles, ivld toggles every cycle.
REQ-038 width=8, depth=4, count=2; assert arst_n=0 between clock edges -> ivld=0, count=0, rdy=1, idat=0x00 immediately; after release, push 0xA5 -> ivld=1, idat=0xA5 next cycle.
REQ-039 depth=0: toggle dat, vld, irdy randomly without a clock -> idat, ivld, rdy follow the inputs in the same delta and count=0.
